arm_inst_encoder: RTL and testbench
===================================

# arm_inst_encoder

Sequential ARM instruction encoder: the write-side counterpart of the CPU's instruction decoder. It accepts symbolic instruction requests over a valid/ready handshake, such as kind, condition, opcode, registers and immediate or branch target. It packs each request into the 32-bit ARM encoding and writes the words into instruction memory at consecutive word addresses. It sits between the testbench/program-loader front end and the instruction memory write port.

## Interface
- ADDR_W, 8: instruction memory word-address width; depth = 2^ADDR_W.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  one-cycle pulse; pointer to 0, clears full/err/count (ignored unless in IDLE or FULL).
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept.
- req_kind  in  2  0 = data, 1 = load, 2 = branch, 3 = reserved.
- req_cond  in  4  condition field.
- req_op  in  4  data-processing opcode.
- req_imm_en  in  1  operand2/offset is immediate.
- req_rd, req_rn, req_rm  in  4 each  register numbers.
- req_imm  in  12  data: 8-bit imm in [7:0]; load: 12-bit positive offset.
- req_target  in  ADDR_W  branch target, absolute word address.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded word.
- imem_ready  in  1  memory accepts write this cycle.
- full  out  1  last address written; no further accepts.
- err  out  1  sticky; a request was rejected.
- count  out  ADDR_W+1  words written since reset/restart.

## Operation
- FSM: IDLE → ENC → WRITE → IDLE; WRITE → FULL when the written address is 2^ADDR_W−1; ENC → IDLE on a rejected request.
- IDLE: req_ready=1; on req_valid register all fields, go ENC.
- ENC: build word into a register. Data: cond|00|I|op|S|Rn|Rd|op2. S=1 only for TST/TEQ/CMP/CMN. op2 = imm8 (rot 0) if I, else Rm with no shift. Load: cond|010|P=1|U=1|B=0|W=0|L=1|Rn|Rd|imm12; register offset (I=1, Rm) when !req_imm_en. Branch: cond|101|L=0|off24, off = target − (ptr + 2), signed, in words.
- Kind 3 is always rejected: err set, nothing written, back to IDLE.
- WRITE: imem_we=1, imem_addr=ptr, imem_wdata held stable until imem_ready. On handshake: ptr+1, count+1.
- FULL: req_ready=0, imem_we=0; leaves only on restart or reset.
- Pointer never wraps; overflow is prevented by FULL.
- Reset values: FSM IDLE, ptr 0, count 0, full 0, err 0, imem_we 0, imem_addr 0, imem_wdata 0, req_ready 0 in the reset cycle then 1.
- reset mid-WRITE: write aborted, imem_we 0 next cycle, no count increment.
- restart while busy (ENC/WRITE): ignored.

## Timing
- Request accepted in cycle N (req_valid & req_ready).
- imem_we first high in cycle N+2.
- With imem_ready tied high, the write completes in N+2; req_ready returns in N+3. Peak throughput is one instruction per 3 cycles.
- Each cycle imem_ready is low adds one cycle of latency.
- req_ready is a registered function of state only, with no combinational path from req_valid.
- full and count update in the cycle after the final write handshake.

## Configuration
- ARM_ENC_RANGE_CHECK_EN defined: these requests are rejected (err set, no write):
  - data immediate with req_imm[11:8] ≠ 0;
  - branch offset outside [−2^23, 2^23−1];
  - any register field equal to 15 on kind 0/1.
- ARM_ENC_RANGE_CHECK_EN undefined: the same values are silently truncated or encoded as-is; err is set only by kind 3.

## Structure
- Shared package `arm_constants.v`: cond codes, data opcodes, B_CODE/D_CODE/L_CODE, field MSB/LSB macros, kind encodings, FSM state encodings. The encoder uses the same field macros the decoder does.
- One sub-module, `arm_field_pack`: combinational word packer with branch-offset arithmetic and range-check outputs. The top level holds the FSM, pointer, handshakes and error logic.

## Test plan
- ADD r1,r2,r3, cond AL, reg → 0xE0821003 at addr 0; imem_we in N+2; count=1.
- MOV r0,#5 (imm_en, op MOV) then LDR r0,[r1,#4] → 0xE3A00005 at 0, 0xE5910004 at 1; bench decoder round-trip matches kind/cond/regs.
- B from ptr 0 to target 4 → 0xEA000002. From ptr 10 to target 3 → 0xEAFFFFF7.
- imem_ready low for 3 cycles during WRITE → addr/wdata stable, single write, ready returns 3 cycles late.
- ADDR_W=2: four writes → full=1, req_ready=0, fifth request ignored. Then restart → ptr 0, count 0, accepts again.
- kind=3 → err=1, no imem_we. With ARM_ENC_RANGE_CHECK_EN, data imm 0x1FF → err, no write. Without it, writes imm 0xFF. Reset asserted during WRITE → imem_we 0 next cycle, count unchanged.

Source files
------------

// File: rtl/arm_inst_encoder_pkg.sv
// Shared constants for the ARM instruction encoder: field positions, class codes,
// request kinds and FSM state encodings (same field layout the decoder uses).
package arm_inst_encoder_pkg;

  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int I_BIT    = 25;
  localparam int OP_MSB   = 24;
  localparam int OP_LSB   = 21;
  localparam int S_BIT    = 20;
  localparam int RN_MSB   = 19;
  localparam int RN_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 12;

  localparam logic [1:0] D_CODE = 2'b00;
  localparam logic [1:0] L_CODE = 2'b01;
  localparam logic [2:0] B_CODE = 3'b101;

  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;

  typedef enum logic [1:0] {
    KIND_DATA   = 2'd0,
    KIND_LOAD   = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  // Compare-class opcodes only exist to set flags, so they always carry S=1.
  function automatic logic sets_flags(input logic [3:0] op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/arm_inst_encoder_field_pack.sv
// Combinational packer: builds the 32-bit ARM word from registered request fields
// and reports reserved-kind and out-of-range conditions.
module arm_inst_encoder_field_pack
  import arm_inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]        kind_i,
  input  logic [3:0]        cond_i,
  input  logic [3:0]        op_i,
  input  logic              imm_en_i,
  input  logic [3:0]        rd_i,
  input  logic [3:0]        rn_i,
  input  logic [3:0]        rm_i,
  input  logic [11:0]       imm_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] ptr_i,
  output logic [31:0]       word_o,
  output logic              kind_err_o,
  output logic              range_err_o
);

  logic signed [31:0] br_off_s;
  logic               br_in_range_s;
  logic               reg_pc_s;

  // The branch is executed from ptr with the pipeline two words ahead.
  assign br_off_s      = $signed({{(32-ADDR_W){1'b0}}, target_i})
                       - $signed({{(32-ADDR_W){1'b0}}, ptr_i}) - 32'sd2;
  assign br_in_range_s = (&br_off_s[31:23]) | ~(|br_off_s[31:23]);
  assign reg_pc_s      = (rd_i == 4'd15) | (rn_i == 4'd15) | (rm_i == 4'd15);

  always_comb begin
    word_o                    = 32'h0000_0000;
    kind_err_o                = 1'b0;
    range_err_o               = 1'b0;
    word_o[COND_MSB:COND_LSB] = cond_i;
    case (kind_i)
      KIND_DATA: begin
        word_o[27:26]         = D_CODE;
        word_o[I_BIT]         = imm_en_i;
        word_o[OP_MSB:OP_LSB] = op_i;
        word_o[S_BIT]         = sets_flags(op_i);
        word_o[RN_MSB:RN_LSB] = rn_i;
        word_o[RD_MSB:RD_LSB] = rd_i;
        if (imm_en_i) begin
          word_o[11:0] = {4'h0, imm_i[7:0]};
        end else begin
          word_o[11:0] = {8'h00, rm_i};
        end
        range_err_o = (imm_en_i & (|imm_i[11:8])) | reg_pc_s;
      end
      KIND_LOAD: begin
        word_o[27:26]         = L_CODE;
        word_o[I_BIT]         = ~imm_en_i;
        word_o[24:20]         = 5'b11001;
        word_o[RN_MSB:RN_LSB] = rn_i;
        word_o[RD_MSB:RD_LSB] = rd_i;
        if (imm_en_i) begin
          word_o[11:0] = imm_i;
        end else begin
          word_o[11:0] = {8'h00, rm_i};
        end
        range_err_o = reg_pc_s;
      end
      KIND_BRANCH: begin
        word_o[27:25] = B_CODE;
        word_o[24]    = 1'b0;
        word_o[23:0]  = br_off_s[23:0];
        range_err_o   = ~br_in_range_s;
      end
      default: begin
        kind_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/arm_inst_encoder.sv
// Sequential ARM instruction encoder writing packed words to instruction memory.
// Define ARM_ENC_RANGE_CHECK_EN to reject out-of-range fields instead of truncating.
module arm_inst_encoder
  import arm_inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [3:0]        req_cond,
  input  logic [3:0]        req_op,
  input  logic              req_imm_en,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rm,
  input  logic [11:0]       req_imm,
  input  logic [ADDR_W-1:0] req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

`ifdef ARM_ENC_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              full_q, req_ready_q, imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [1:0]        kind_q;
  logic [3:0]        cond_q, op_q, rd_q, rn_q, rm_q;
  logic              imm_en_q;
  logic [11:0]       imm_q;
  logic [ADDR_W-1:0] target_q;
  logic              capture_s, kind_err_s, range_err_s, reject_s;
  logic [31:0]       word_s;

  arm_inst_encoder_field_pack #(.ADDR_W(ADDR_W)) u_pack (
    .kind_i     (kind_q),
    .cond_i     (cond_q),
    .op_i       (op_q),
    .imm_en_i   (imm_en_q),
    .rd_i       (rd_q),
    .rn_i       (rn_q),
    .rm_i       (rm_q),
    .imm_i      (imm_q),
    .target_i   (target_q),
    .ptr_i      (ptr_q),
    .word_o     (word_s),
    .kind_err_o (kind_err_s),
    .range_err_o(range_err_s)
  );

  assign reject_s = kind_err_s | (RANGE_CHECK & range_err_s);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (restart) begin
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          ptr_d = ptr_q;
        end
        if (req_valid) begin
          capture_s = 1'b1;
          state_d   = ST_ENC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENC: begin
        if (reject_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (imem_ready) begin
          count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
          // The last word parks in FULL instead of wrapping the pointer.
          if (&ptr_q) begin
            state_d = ST_FULL;
          end else begin
            ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_FULL: begin
        if (restart) begin
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      full_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0000_0000;
      kind_q       <= 2'd0;
      cond_q       <= 4'h0;
      op_q         <= 4'h0;
      imm_en_q     <= 1'b0;
      rd_q         <= 4'h0;
      rn_q         <= 4'h0;
      rm_q         <= 4'h0;
      imm_q        <= 12'h000;
      target_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      full_q      <= (state_d == ST_FULL);
      req_ready_q <= (state_d == ST_IDLE);
      imem_we_q   <= (state_d == ST_WRITE);
      if ((state_q == ST_ENC) && !reject_s) begin
        imem_addr_q  <= ptr_q;
        imem_wdata_q <= word_s;
      end
      if (capture_s) begin
        kind_q   <= req_kind;
        cond_q   <= req_cond;
        op_q     <= req_op;
        imm_en_q <= req_imm_en;
        rd_q     <= req_rd;
        rn_q     <= req_rn;
        rm_q     <= req_rm;
        imm_q    <= req_imm;
        target_q <= req_target;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Directed self-checking bench for arm_inst_encoder (ADDR_W = 8).
module tb_arm_inst_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'd0;
  logic [3:0]  req_cond = 4'h0, req_op = 4'h0;
  logic        req_imm_en = 1'b0;
  logic [3:0]  req_rd = 4'h0, req_rn = 4'h0, req_rm = 4'h0;
  logic [11:0] req_imm = 12'h000;
  logic [7:0]  req_target = 8'h00;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready = 1'b1;
  logic        full, err;
  logic [8:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  arm_inst_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cond(req_cond), .req_op(req_op),
    .req_imm_en(req_imm_en), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .full(full), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent decoder: class bits back to request kind.
  function automatic logic [1:0] dec_kind(input logic [31:0] w);
    logic [1:0] k;
    if (w[27:26] == 2'b00) k = 2'd0;
    else if (w[27:26] == 2'b01) k = 2'd1;
    else if (w[27:25] == 3'b101) k = 2'd2;
    else k = 2'd3;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [3:0] c, input logic [3:0] op,
                      input logic ie, input logic [3:0] rd, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [11:0] imm, input logic [7:0] tgt);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
    req_kind = k; req_cond = c; req_op = op; req_imm_en = ie;
    req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Called in the cycle after acceptance; imem_ready assumed high.
  task automatic expect_write(input string tag, input logic [7:0] addr, input logic [31:0] word,
                              input logic [8:0] cnt, input logic [1:0] kind, input logic [3:0] rd);
    check_val({tag, "_we_n1"}, {31'd0, imem_we}, 32'd0);
    tick();
    check_val({tag, "_we_n2"}, {31'd0, imem_we}, 32'd1);
    check_val({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, addr});
    check_val({tag, "_wdata"}, imem_wdata, word);
    check_val({tag, "_rt_kind"}, {30'd0, dec_kind(imem_wdata)}, {30'd0, kind});
    check_val({tag, "_rt_cond"}, {28'd0, imem_wdata[31:28]}, 32'hE);
    if (kind != 2'd2) check_val({tag, "_rt_rd"}, {28'd0, imem_wdata[15:12]}, {28'd0, rd});
    tick();
    check_val({tag, "_we_n3"}, {31'd0, imem_we}, 32'd0);
    check_val({tag, "_count"}, {23'd0, count}, {23'd0, cnt});
    check_val({tag, "_ready_n3"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    logic [31:0] held_word;
    // Reset state
    tick();
    check_val("rst_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_we", {31'd0, imem_we}, 32'd0);
    check_val("rst_addr", {24'd0, imem_addr}, 32'd0);
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_count", {23'd0, count}, 32'd0);
    check_val("rst_full_err", {30'd0, full, err}, 32'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // ADD r1,r2,r3
    send(2'd0, 4'hE, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 8'd0);
    expect_write("add", 8'd0, 32'hE082_1003, 9'd1, 2'd0, 4'd1);

    // MOV r0,#5 ; LDR r0,[r1,#4]
    pulse_restart();
    check_val("restart_count", {23'd0, count}, 32'd0);
    send(2'd0, 4'hE, 4'hD, 1'b1, 4'd0, 4'd0, 4'd0, 12'h005, 8'd0);
    expect_write("mov", 8'd0, 32'hE3A0_0005, 9'd1, 2'd0, 4'd0);
    send(2'd1, 4'hE, 4'h0, 1'b1, 4'd0, 4'd1, 4'd0, 12'h004, 8'd0);
    expect_write("ldr", 8'd1, 32'hE591_0004, 9'd2, 2'd1, 4'd0);

    // Branches forward and backward
    pulse_restart();
    send(2'd2, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 8'd4);
    expect_write("b_fwd", 8'd0, 32'hEA00_0002, 9'd1, 2'd2, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      send(2'd0, 4'hE, 4'hD, 1'b1, 4'd0, 4'd0, 4'd0, 12'(i), 8'd0);
      expect_write("fill", 8'(i), 32'hE3A0_0000 | 32'(i), 9'(i + 1), 2'd0, 4'd0);
    end
    send(2'd2, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 8'd3);
    expect_write("b_back", 8'd10, 32'hEAFF_FFF7, 9'd11, 2'd2, 4'd0);

    // Back-pressure: imem_ready low for 3 cycles
    imem_ready = 1'b0;
    send(2'd0, 4'hE, 4'h4, 1'b0, 4'd4, 4'd5, 4'd6, 12'h000, 8'd0);
    tick();
    held_word = 32'hE085_4006;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_we", {31'd0, imem_we}, 32'd1);
      check_val("bp_addr", {24'd0, imem_addr}, 32'd11);
      check_val("bp_wdata", imem_wdata, held_word);
      tick();
    end
    imem_ready = 1'b1;
    check_val("bp_we_last", {31'd0, imem_we}, 32'd1);
    check_val("bp_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    check_val("bp_we_done", {31'd0, imem_we}, 32'd0);
    check_val("bp_ready_back", {31'd0, req_ready}, 32'd1);
    check_val("bp_count", {23'd0, count}, 32'd12);

    // Reserved kind
    send(2'd3, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 8'd0);
    check_val("k3_we_n1", {31'd0, imem_we}, 32'd0);
    tick();
    check_val("k3_we_n2", {31'd0, imem_we}, 32'd0);
    check_val("k3_err", {31'd0, err}, 32'd1);
    check_val("k3_count", {23'd0, count}, 32'd12);
    pulse_restart();
    check_val("restart_err", {31'd0, err}, 32'd0);

    // Oversized data immediate
    send(2'd0, 4'hE, 4'hD, 1'b1, 4'd0, 4'd0, 4'd0, 12'h1FF, 8'd0);
`ifdef ARM_ENC_RANGE_CHECK_EN
    tick();
    check_val("imm_rc_we", {31'd0, imem_we}, 32'd0);
    check_val("imm_rc_err", {31'd0, err}, 32'd1);
    check_val("imm_rc_count", {23'd0, count}, 32'd0);
`else
    expect_write("imm_trunc", 8'd0, 32'hE3A0_00FF, 9'd1, 2'd0, 4'd0);
    check_val("imm_trunc_err", {31'd0, err}, 32'd0);
`endif

    // Reset during WRITE
    imem_ready = 1'b0;
    send(2'd0, 4'hE, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 8'd0);
    tick();
    check_val("rw_we_before", {31'd0, imem_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_ready = 1'b1;
    check_val("rw_we_after", {31'd0, imem_we}, 32'd0);
    check_val("rw_count", {23'd0, count}, 32'd0);
    tick();
    check_val("rw_we_quiet", {31'd0, imem_we}, 32'd0);
    check_val("rw_ready", {31'd0, req_ready}, 32'd1);

    // Fill memory to full
    for (int i = 0; i < 256; i++) begin
      send(2'd0, 4'hE, 4'hD, 1'b1, 4'd0, 4'd0, 4'd0, 12'h000, 8'd0);
      tick();
      if (i == 255) check_val("last_addr", {24'd0, imem_addr}, 32'd255);
      tick();
      if (i == 254) check_val("not_full_yet", {31'd0, full}, 32'd0);
    end
    check_val("full_flag", {31'd0, full}, 32'd1);
    check_val("full_count", {23'd0, count}, 32'd256);
    check_val("full_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("full_no_we", {31'd0, imem_we}, 32'd0);
    end
    req_valid = 1'b0;
    pulse_restart();
    check_val("rs_full", {31'd0, full}, 32'd0);
    check_val("rs_count", {23'd0, count}, 32'd0);
    send(2'd0, 4'hE, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 8'd0);
    expect_write("after_full", 8'd0, 32'hE082_1003, 9'd1, 2'd0, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
